// File: rtl/bps_gen_pkg.sv
// Shared types and default divisors for the UART bit-rate generator.
package bps_gen_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int MIN_DIV  = 32;
    localparam int DEF_DIV0 = 5208;
    localparam int DEF_DIV1 = 2604;
    localparam int DEF_DIV2 = 434;
    localparam int DEF_DIV3 = 868;

endpackage

// File: rtl/bps_div_sel.sv
// Custom divisor register with minimum-value filter and rate select mux.
module bps_div_sel
    import bps_gen_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int MIN   = MIN_DIV,
    parameter int DIV0  = DEF_DIV0,
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       baud_sel,
    input  logic             div_we,
    input  logic [CNT_W-1:0] div_in,
    output logic [CNT_W-1:0] div_sel
);

    logic [CNT_W-1:0] div_cus;

    // Too-small divisors would leave no room for the oversample counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cus <= CNT_W'(DIV3);
        end else if (div_we && div_in >= CNT_W'(MIN)) begin
            div_cus <= div_in;
        end
    end

    always_comb begin
        div_sel = div_cus;
        unique case (baud_sel)
            2'd0:    div_sel = CNT_W'(DIV0);
            2'd1:    div_sel = CNT_W'(DIV1);
            2'd2:    div_sel = CNT_W'(DIV2);
            default: div_sel = div_cus;
        endcase
    end

endmodule

// File: rtl/bps_gen_param.sv
// UART frame timer: mid-bit sample, bit edge, 16x tick, bit index, frame end.
module bps_gen_param
    import bps_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int OS_LOG2    = 4,
    parameter int FRAME_BITS = 10,
    parameter int DIV0       = DEF_DIV0,
    parameter int DIV1       = DEF_DIV1,
    parameter int DIV2       = DEF_DIV2,
    parameter int DIV3       = DEF_DIV3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bps_start,
    input  logic [1:0]       baud_sel,
    input  logic             div_we,
    input  logic [CNT_W-1:0] div_in,
    output logic             bps_clk,
    output logic             bit_edge,
    output logic             os_tick,
    output logic [3:0]       bit_idx,
    output logic             frame_done,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] os_cnt;
    logic [CNT_W-1:0] div_l;
    logic [CNT_W-1:0] div_sel;
    logic [3:0]       bit_q;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] os_div;
    logic             run;
    logic             cnt_last;
    logic             os_last;
    logic             bit_last;

    bps_div_sel #(
        .CNT_W (CNT_W),
        .MIN   (2 ** (OS_LOG2 + 1)),
        .DIV0  (DIV0),
        .DIV1  (DIV1),
        .DIV2  (DIV2),
        .DIV3  (DIV3)
    ) u_div_sel (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .div_we   (div_we),
        .div_in   (div_in),
        .div_sel  (div_sel)
    );

    assign half     = div_l >> 1;
    assign os_div   = div_l >> OS_LOG2;
    assign run      = (state == RUN);
    assign cnt_last = (cnt == div_l - CNT_W'(1));
    assign os_last  = (os_cnt == os_div - CNT_W'(1));
    assign bit_last = (bit_q == 4'(FRAME_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            os_cnt <= '0;
            bit_q  <= '0;
            div_l  <= CNT_W'(DIV0);
        end else begin
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    os_cnt <= '0;
                    bit_q  <= '0;
                    if (bps_start) begin
                        div_l <= div_sel;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!bps_start) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        os_cnt <= '0;
                        bit_q  <= '0;
                    end else if (cnt_last) begin
                        cnt    <= '0;
                        os_cnt <= '0;
                        if (bit_last) begin
                            // Back-to-back frame picks up the current select.
                            bit_q <= '0;
                            div_l <= div_sel;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        os_cnt <= os_last ? '0 : os_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bps_clk    = run && (cnt == half);
    assign bit_edge   = run && cnt_last;
    assign os_tick    = run && os_last;
    assign frame_done = run && cnt_last && bit_last;
    assign bit_idx    = run ? bit_q : 4'd0;
    assign busy       = run;

endmodule

// File: tb/tb_bps_gen_param.sv
// Randomised bench for bps_gen_param against a frame-position reference model.
module tb_bps_gen_param;

    localparam int D0 = 5208;
    localparam int D1 = 2604;
    localparam int D2 = 434;
    localparam int D3 = 868;
    localparam int FB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bps_start = 1'b0;
    logic [1:0]  baud_sel = 2'd0;
    logic        div_we = 1'b0;
    logic [15:0] div_in = 16'd0;
    logic        bps_clk;
    logic        bit_edge;
    logic        os_tick;
    logic [3:0]  bit_idx;
    logic        frame_done;
    logic        busy;
    logic [8:0]  dut_out;

    int n_pass = 0;
    int n_chk  = 0;
    int edge_n = 0;
    int n;
    int fd_cnt;

    // Reference: cycles elapsed in the frame, latched divisor, custom value.
    bit m_run;
    int m_t;
    int m_div;
    int m_cus;

    bps_gen_param dut (
        .clk        (clk),
        .rst        (rst),
        .bps_start  (bps_start),
        .baud_sel   (baud_sel),
        .div_we     (div_we),
        .div_in     (div_in),
        .bps_clk    (bps_clk),
        .bit_edge   (bit_edge),
        .os_tick    (os_tick),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    assign dut_out = {bps_clk, bit_edge, os_tick, frame_done, busy, bit_idx};

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    endtask

    function automatic int sel_div(input int s);
        case (s)
            0:       return D0;
            1:       return D1;
            2:       return D2;
            default: return m_cus;
        endcase
    endfunction

    function automatic logic [8:0] model_out();
        int b, c, os;
        logic bc, be, ot, fd;
        if (!m_run) return 9'd0;
        b  = m_t / m_div;
        c  = m_t % m_div;
        os = m_div / 16;
        bc = (c == m_div / 2);
        be = (c == m_div - 1);
        ot = ((c % os) == os - 1);
        fd = be && (b == FB - 1);
        return {bc, be, ot, fd, 1'b1, 4'(b)};
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_t   = 0;
        m_div = D0;
        m_cus = D3;
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (!m_run) begin
            if (bps_start) begin
                m_run = 1;
                m_t   = 0;
                m_div = sel_div(int'(baud_sel));
            end
        end else if (!bps_start) begin
            m_run = 0;
        end else begin
            m_t++;
            if (m_t == FB * m_div) begin
                m_t   = 0;
                m_div = sel_div(int'(baud_sel));
            end
        end
        if (div_we && div_in >= 16'd32) m_cus = int'(div_in);
        @(negedge clk);
        check("outs", int'(dut_out), int'(model_out()));
    endtask

    function automatic logic sig_of(input int w);
        case (w)
            0:       return bps_clk;
            1:       return bit_edge;
            2:       return frame_done;
            default: return os_tick;
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, output int hit);
        hit = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sig_of(w)) begin
                hit = edge_n;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outs", int'(dut_out), 0);
        rst = 1'b1;
        repeat (2) step();

        // 9600 frame, select moved to 115200 mid-frame
        baud_sel  = 2'd0;
        bps_start = 1'b1;
        edge_n    = 0;
        wait_for(0, 3000, n);
        check("first_bps_clk", n, 2605);
        wait_for(1, 3000, n);
        check("first_bit_edge", n, 5208);
        baud_sel = 2'd2;
        wait_for(2, 50000, n);
        check("frame0_done", n, 52080);
        wait_for(2, 5000, n);
        check("frame1_done", n, 52080 + 4340);
        bps_start = 1'b0;
        step();
        check("idle_after", int'(busy), 0);

        // undersized custom write is dropped
        div_in = 16'd20;
        div_we = 1'b1;
        step();
        div_we    = 1'b0;
        baud_sel  = 2'd3;
        bps_start = 1'b1;
        edge_n    = 0;
        wait_for(2, 9000, n);
        check("ignored_wr_done", n, 8680);
        bps_start = 1'b0;
        step();

        // minimum custom divisor
        div_in = 16'd32;
        div_we = 1'b1;
        step();
        div_we    = 1'b0;
        bps_start = 1'b1;
        edge_n    = 0;
        wait_for(3, 10, n);
        check("first_os_tick", n, 2);
        wait_for(0, 40, n);
        check("bps_clk_32", n, 17);
        wait_for(2, 400, n);
        check("frame_done_32", n, 320);
        bps_start = 1'b0;
        step();

        // abort during bit 4, then restart
        bps_start = 1'b1;
        for (int i = 0; i < 200 && bit_idx != 4'd4; i++) step();
        check("reached_bit4", int'(bit_idx), 4);
        repeat (5) step();
        bps_start = 1'b0;
        step();
        check("abort_busy", int'(busy), 0);
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check("abort_no_fd", fd_cnt, 0);
        bps_start = 1'b1;
        step();
        check("restart_busy", int'(busy), 1);
        check("restart_idx", int'(bit_idx), 0);

        // random select churn, writes and start drops
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) bps_start = ~bps_start;
            baud_sel = 2'($urandom_range(0, 3));
            div_we   = ($urandom_range(0, 49) == 0);
            div_in   = 16'($urandom_range(0, 80));
            step();
        end
        div_we = 1'b0;

        // asynchronous reset mid-bit
        baud_sel  = 2'd3;
        bps_start = 1'b1;
        repeat (50) step();
        #2 rst = 1'b0;
        #1;
        check("arst_outs", int'(dut_out), 0);
        model_reset();
        @(negedge clk);
        bps_start = 1'b0;
        rst       = 1'b1;
        repeat (5) step();
        check("arst_idle", int'(busy), 0);
        bps_start = 1'b1;
        step();
        check("arst_restart", int'(busy), 1);
        bps_start = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bps_gen_param.md
# bps_gen_param

Parametrised UART bit-rate generator, the successor to the fixed 9600-baud divider. It times one UART frame: the rate is picked at run time from a table or a programmable divisor, and it produces a mid-bit sample pulse, a bit-boundary pulse, a 16x oversample tick, a bit index and an end-of-frame pulse. It sits between the system clock and the UART TX/RX shifters, and drives both from one timing source.

## Interface
- `CNT_W`, 16: width of the divisor and bit counter.
- `OS_LOG2`, 4: log2 of the oversample factor (16x).
- `FRAME_BITS`, 10: bits per frame (start + 8 data + stop).
- `DIV0`, 5208: divisor for sel 0 (50 MHz / 9600).
- `DIV1`, 2604: divisor for sel 1 (19200).
- `DIV2`, 434: divisor for sel 2 (115200).
- `DIV3`, 868: reset value of the custom divisor register (57600).
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `bps_start`, in, 1: run enable, level; high = frame in progress.
- `baud_sel`, in, 2: divisor select; 0..2 = DIV0..DIV2, 3 = custom register.
- `div_we`, in, 1: write strobe for the custom divisor.
- `div_in`, in, CNT_W: custom divisor value.
- `bps_clk`, out, 1: mid-bit sample pulse, 1 cycle.
- `bit_edge`, out, 1: bit-boundary pulse, 1 cycle.
- `os_tick`, out, 1: oversample tick, 1 cycle.
- `bit_idx`, out, 4: index of the current bit, 0..FRAME_BITS-1.
- `frame_done`, out, 1: last-bit boundary pulse, 1 cycle.
- `busy`, out, 1: high in RUN.

## Operation
- Registers:
  - `state` (IDLE/RUN).
  - `cnt` (CNT_W).
  - `os_cnt` (CNT_W).
  - `div_l`, the latched divisor.
  - `bit_idx`.
  - `div_cus`, the custom divisor.
- Derived values: `half = div_l >> 1`; `os_div = div_l >> OS_LOG2`.
- Reset (rst low, async): state IDLE, `cnt`/`os_cnt`/`bit_idx` = 0, `div_l` = DIV0, `div_cus` = DIV3. All outputs are 0.
- Custom divisor write: `div_we` high with `div_in >= 2^(OS_LOG2+1)` (32) loads `div_cus`. Smaller values are ignored and the register is unchanged. Writes take effect at the next latch only.
- IDLE: counters held at 0. When `bps_start` = 1 is sampled: `div_l` ← selected divisor (`div_cus` if sel = 3), go to RUN.
- RUN, each cycle with `bps_start` = 1:
  - `cnt` increments and wraps to 0 at `div_l-1`.
  - `os_cnt` increments and wraps to 0 at `os_div-1`. It is also forced to 0 when `cnt` wraps, so the last partial oversample period of a bit is truncated.
  - When `cnt` wraps:
    - If `bit_idx` < FRAME_BITS-1: `bit_idx` increments.
    - Otherwise: `bit_idx` ← 0. If `bps_start` is still 1, re-latch `div_l` from the current `baud_sel` and stay in RUN (back-to-back frames). If not, go to IDLE.
- Abort: `bps_start` = 0 in RUN → next cycle is IDLE with all counters 0. No `frame_done` is issued.
- `baud_sel` changes mid-frame are ignored until the next latch.
- Outputs are combinational decodes of registered state and are gated by state == RUN:
  - `bps_clk` = (`cnt` == `half`).
  - `bit_edge` = (`cnt` == `div_l-1`).
  - `os_tick` = (`os_cnt` == `os_div-1`).
  - `frame_done` = `bit_edge` & (`bit_idx` == FRAME_BITS-1).
  - `busy` = RUN.

## Timing
- Let edge 0 be the edge that samples `bps_start` high in IDLE. After edge 1 the state is RUN with `cnt` = 0.
- `bps_clk` is high in the cycle after edge 1+`half`. For `div_l` = 5208 that is after edge 2605.
- `bit_edge` is high in the cycle after edge `div_l`. Bit n boundary: after edge (n+1)·`div_l`.
- `frame_done` is high in the cycle after edge FRAME_BITS·`div_l`. Next cycle: IDLE, or RUN with `cnt` = 0 and `bit_idx` = 0.
- Back-to-back frames have no gap cycle. Period is exactly `div_l` cycles per bit.
- First `os_tick` is high in the cycle after edge `os_div`.
- Async reset mid-frame clears all outputs immediately. Pulses never exceed 1 cycle.

## Structure
- Package `bps_gen_pkg`:
  - State enum {IDLE, RUN}.
  - `MIN_DIV` = 32.
  - Default divisor constants DIV0..DIV3.
- One sub-module, `bps_div_sel`: holds the `div_cus` register with its write filter, and muxes `baud_sel` to the divisor value. The counters and state machine stay in the top level.

## Test plan
- Reset, then sel = 0, `bps_start` held high:
  - `bps_clk` after edge 2605.
  - `bit_edge` after edge 5208.
  - `frame_done` after edge 52080.
  - `bit_idx` sequence 0..9.
- Write `div_in` = 32, sel = 3, `bps_start` high:
  - `os_tick` every 2 cycles.
  - `bps_clk` at `cnt` = 16.
  - `frame_done` after edge 320.
- Write `div_in` = 20 → ignored; the following frame still uses 868 per bit.
- Drop `bps_start` at bit 4 → `busy` = 0 next cycle, no `frame_done`. Restart → `bit_idx` begins at 0.
- Change `baud_sel` 0→2 mid-frame with `bps_start` held → current frame stays 5208 per bit; next frame runs 434 per bit with no gap cycle.
- Assert `rst` low mid-bit → all outputs 0 immediately. After release, stays IDLE until `bps_start` is sampled high.
